// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with stall-buffered redirects; optional return-address stack under PC_RAS_EN
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vector,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirected,
    output logic             pending,
    output logic             ras_empty
);

    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] ret_target;
    logic [WIDTH-1:0] jump_dest;
    logic [WIDTH-1:0] redirect_target;
    logic             redirect_req;
    logic             stack_empty;

    assign pc_plus         = pc + WIDTH'(STEP);
    assign redirect_req    = jump | branch_taken;
    assign jump_dest       = ret ? ret_target : jump_target;
    assign redirect_target = jump ? jump_dest : branch_target;
    assign ras_empty       = stack_empty;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW:0]      ras_count;
    logic [PW-1:0]    top_idx;
    logic             jump_accept;

    // ras_ptr names the next free slot; the circular wrap overwrites the oldest entry when full
    assign top_idx     = ras_ptr - 1'b1;
    assign stack_empty = (ras_count == '0);
    assign ret_target  = stack_empty ? jump_target : ras_mem[top_idx];
    assign jump_accept = jump & ~trap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (jump_accept) begin
            if (call && ret && !stack_empty) begin
                ras_mem[top_idx] <= pc_plus;
            end else if (call) begin
                ras_mem[ras_ptr] <= pc_plus;
                ras_ptr          <= ras_ptr + 1'b1;
                if (ras_count != (PW+1)'(RAS_DEPTH))
                    ras_count <= ras_count + 1'b1;
            end else if (ret && !stack_empty) begin
                ras_ptr   <= top_idx;
                ras_count <= ras_count - 1'b1;
            end
        end
    end
`else
    logic unused_call;

    assign unused_call = call;
    assign stack_empty = 1'b1;
    assign ret_target  = jump_target;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_VECTOR;
            redirected  <= 1'b0;
            pending     <= 1'b0;
            pend_target <= '0;
        end else if (trap) begin
            pc         <= trap_vector;
            redirected <= 1'b1;
            pending    <= 1'b0;
        end else if (stall) begin
            redirected <= 1'b0;
            if (redirect_req) begin
                pending     <= 1'b1;
                pend_target <= redirect_target;
            end
        end else if (redirect_req) begin
            pc         <= redirect_target;
            redirected <= 1'b1;
            pending    <= 1'b0;
        end else if (pending) begin
            pc         <= pend_target;
            redirected <= 1'b1;
            pending    <= 1'b0;
        end else begin
            pc         <= pc_plus;
            redirected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized bench for pc_unit against a queue-based behavioural model
module tb_pc_unit;

    localparam int          RD = 2;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst, stall, trap, jump, call, ret, branch_taken;
    logic [31:0] trap_vector, jump_target, branch_target;
    logic [31:0] pc, pc_plus;
    logic        redirected, pending, ras_empty;

    logic       rst8, zero1;
    logic [7:0] zero8, pc8, pc_plus8;
    logic       red8, pend8, empty8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc, m_ptgt;
    logic        m_red, m_pend, m_valid;
    logic [31:0] m_stack[$];
    bit          ras_en;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(RV), .RAS_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vector(trap_vector),
        .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .pc_plus(pc_plus), .redirected(redirected), .pending(pending),
        .ras_empty(ras_empty)
    );

    pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hFC), .RAS_DEPTH(RD)) dut8 (
        .clk(clk), .rst(rst8), .stall(zero1), .trap(zero1), .trap_vector(zero8),
        .jump(zero1), .jump_target(zero8), .call(zero1), .ret(zero1),
        .branch_taken(zero1), .branch_target(zero8),
        .pc(pc8), .pc_plus(pc_plus8), .redirected(red8), .pending(pend8),
        .ras_empty(empty8)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Next state straight from the rules: priority trap > jump > branch > sequential
    function automatic void model_update();
        logic [31:0] tgt;
        logic        redir;
        if (!rst) begin
            m_pc = RV; m_red = 0; m_pend = 0; m_stack.delete(); m_valid = 1;
            return;
        end
        if (!m_valid) return;
        if (trap) begin
            m_pc = trap_vector; m_red = 1; m_pend = 0;
            return;
        end
        redir = jump | branch_taken;
        tgt   = branch_target;
        if (jump) begin
            tgt = jump_target;
            if (ras_en) begin
                if (ret && m_stack.size() > 0) tgt = m_stack[$];
                if (call && ret) begin
                    if (m_stack.size() > 0) m_stack[m_stack.size()-1] = m_pc + 32'd4;
                    else m_stack.push_back(m_pc + 32'd4);
                end else if (call) begin
                    m_stack.push_back(m_pc + 32'd4);
                    if (m_stack.size() > RD) void'(m_stack.pop_front());
                end else if (ret && m_stack.size() > 0) begin
                    void'(m_stack.pop_back());
                end
            end
        end
        if (stall) begin
            m_red = 0;
            if (redir) begin m_pend = 1; m_ptgt = tgt; end
        end else if (redir) begin
            m_pc = tgt; m_red = 1; m_pend = 0;
        end else if (m_pend) begin
            m_pc = m_ptgt; m_red = 1; m_pend = 0;
        end else begin
            m_pc = m_pc + 32'd4; m_red = 0;
        end
    endfunction

    function automatic void compare_all();
        if (!m_valid) return;
        chk("pc", pc, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'd4);
        chk("redirected", {31'd0, redirected}, {31'd0, m_red});
        chk("pending", {31'd0, pending}, {31'd0, m_pend});
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, (!ras_en || m_stack.size() == 0)});
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        stall = 0; trap = 0; jump = 0; call = 0; ret = 0; branch_taken = 0;
    endtask

    initial begin
`ifdef PC_RAS_EN
        ras_en = 1;
`else
        ras_en = 0;
`endif
        m_valid = 0; m_pc = '0; m_ptgt = '0; m_red = 0; m_pend = 0;
        zero1 = 0; zero8 = '0;
        idle();
        trap_vector = '0; jump_target = '0; branch_target = '0;
        rst = 0; rst8 = 0;
        step();
        chk("reset_pc", pc, 32'h100);
        chk("reset_red", {31'd0, redirected}, 32'd0);
        chk("reset_empty", {31'd0, ras_empty}, 32'd1);
        chk("w8_reset_pc", {24'd0, pc8}, 32'hFC);
        rst = 1; rst8 = 1;
        step();
        chk("w8_wrap_pc", {24'd0, pc8}, 32'h00);
        chk("w8_wrap_plus", {24'd0, pc_plus8}, 32'h04);
        chk("seq_1", pc, 32'h104);
        step(); chk("seq_2", pc, 32'h108);
        step(); chk("seq_3", pc, 32'h10C);
        chk("seq_red", {31'd0, redirected}, 32'd0);

        jump = 1; jump_target = 32'h10; step(); idle();
        jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        step(); idle();
        chk("prio_pc", pc, 32'h80);
        chk("prio_red", {31'd0, redirected}, 32'd1);
        step();
        chk("after_prio", pc, 32'h84);

        stall = 1; branch_taken = 1; branch_target = 32'h200; step();
        branch_taken = 0; jump = 1; jump_target = 32'h300; step();
        jump = 0; step();
        chk("stall_hold", pc, 32'h84);
        chk("stall_pend", {31'd0, pending}, 32'd1);
        stall = 0; step();
        chk("release_pc", pc, 32'h300);
        chk("release_pend", {31'd0, pending}, 32'd0);

        stall = 1; jump = 1; jump_target = 32'h500; step();
        jump = 0; trap = 1; trap_vector = 32'h8; step();
        chk("trap_pc", pc, 32'h8);
        chk("trap_pend", {31'd0, pending}, 32'd0);
        idle(); rst = 0; stall = 1; step();
        chk("rst_pc", pc, RV);
        rst = 1; stall = 0;

        jump = 1; jump_target = 32'hFFFF_FFFC; step(); idle();
        step();
        chk("wrap_pc", pc, 32'h0);

`ifdef PC_RAS_EN
        rst = 0; step(); rst = 1;
        jump = 1; jump_target = 32'h10; step();
        call = 1; jump_target = 32'h20; step();
        jump_target = 32'h30; step();
        jump_target = 32'h50; step();
        call = 0; ret = 1; jump_target = 32'hEE; step();
        chk("ret_1", pc, 32'h34);
        step();
        chk("ret_2", pc, 32'h24);
        chk("ret_2_empty", {31'd0, ras_empty}, 32'd1);
        step();
        chk("ret_3", pc, 32'hEE);
        idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) != 0);
            stall         = ($urandom_range(0, 9) < 3);
            trap          = ($urandom_range(0, 49) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            call          = $urandom_range(0, 1);
            ret           = $urandom_range(0, 1);
            branch_taken  = ($urandom_range(0, 7) == 0);
            trap_vector   = $urandom;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            branch_target = $urandom;
            step();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
